l1_thresh_sequencer: RTL

Wishbone-master sequencer that loads a set of per-beam trigger thresholds into the L1 trigger wrapper and commits them atomically. On a start pulse it masks all beams, writes each threshold from a local threshold RAM, strobes the threshold-update bit, waits a settle interval, then restores the caller's beam mask. It sits in the wb_clk_i domain, between the housekeeping register block (which owns the threshold RAM and start control) and the L1 trigger wrapper's Wishbone slave port.

---
 rtl/l1_thresh_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/l1_thresh_sequencer.sv
// l1_thresh_sequencer: Wishbone-master sequencer that masks all beams, loads
// per-beam thresholds from the housekeeping threshold RAM, strobes the commit
// bit, waits a settle interval and restores the caller's beam mask.
// Optional feature macro: L1_SEQ_TIMEOUT_EN (ack watchdog with sticky err_o).
module l1_thresh_sequencer #(
  parameter int unsigned NBEAMS        = 48,
  parameter logic [14:0] THR_BASE      = 15'h0800,
  parameter logic [14:0] MASK_ADDR     = 15'h2008,
  parameter logic [14:0] UPDATE_ADDR   = 15'h200C,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic [5:0]  thr_count_i,
  input  logic [31:0] mask_i,
  output logic        thr_rd_o,
  output logic [5:0]  thr_idx_o,
  input  logic [17:0] thr_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [14:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = 6;
  localparam int unsigned ADR_W = 15;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned THR_W = 18;
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned WD_W  = 8;
  localparam logic [IDX_W-1:0] MAX_CNT   = IDX_W'(NBEAMS);
  localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [DAT_W-1:0] ALL_MASK  = 32'hFFFF_FFFF;
  localparam logic [DAT_W-1:0] COMMIT_WD = 32'h8000_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_MASK, S_FETCH, S_FWAIT, S_THR, S_COMMIT, S_SETTLE, S_RESTORE, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [DAT_W-1:0]   mask_q, mask_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               cyc_d, rd_d, busy_d, done_d;
  logic [ADR_W-1:0]   adr_d;
  logic [DAT_W-1:0]   dat_d;
  logic [IDX_W-1:0]   tidx_d;
  logic               wr_req;
  logic [ADR_W-1:0]   wr_adr;
  logic [DAT_W-1:0]   wr_dat;
  state_t             wr_next;
  logic               start_acc_c;
  logic               timeout_c;

  assign wb_sel_o    = 4'hF;
  assign start_acc_c = (state_q == S_IDLE) && start_i;

`ifdef L1_SEQ_TIMEOUT_EN
  logic [WD_W-1:0] wdog_q;

  // Ack watchdog: cleared whenever no transaction is open
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wdog_q <= '0;
    end else if (!wb_cyc_o) begin
      wdog_q <= '0;
    end else if (!wb_ack_i) begin
      wdog_q <= wdog_q + WD_W'(1);
    end
  end

  assign timeout_c = wb_cyc_o && !wb_ack_i && (wdog_q == WD_W'(TIMEOUT - 1));

  // Sticky timeout flag, cleared by an accepted start
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      err_o <= 1'b0;
    end else if (start_acc_c) begin
      err_o <= 1'b0;
    end else if (timeout_c) begin
      err_o <= 1'b1;
    end
  end
`else
  assign timeout_c = 1'b0;
  assign err_o     = 1'b0;
`endif

  // Next-state and next-output logic; write states share one handshake path
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    settle_d = settle_q;
    cyc_d    = 1'b0;
    adr_d    = wb_adr_o;
    dat_d    = wb_dat_o;
    rd_d     = 1'b0;
    tidx_d   = thr_idx_o;
    done_d   = 1'b0;
    idx_inc  = idx_q + IDX_W'(1);
    wr_req   = 1'b0;
    wr_adr   = '0;
    wr_dat   = '0;
    wr_next  = state_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_MASK;
          mask_d  = mask_i;
          cnt_d   = (thr_count_i > MAX_CNT) ? MAX_CNT : thr_count_i;
          idx_d   = '0;
        end
      end
      S_MASK: begin
        wr_req  = 1'b1;
        wr_adr  = MASK_ADDR;
        wr_dat  = ALL_MASK;
        wr_next = (cnt_q == '0) ? S_COMMIT : S_FETCH;
      end
      S_FETCH: begin
        rd_d    = 1'b1;
        tidx_d  = idx_q;
        state_d = S_FWAIT;
      end
      S_FWAIT: begin
        state_d = S_THR;
      end
      S_THR: begin
        // RAM data is valid on the issue cycle and is captured into wb_dat_o there
        wr_req  = 1'b1;
        wr_adr  = THR_BASE + ADR_W'({idx_q, 2'b00});
        wr_dat  = {(DAT_W - THR_W)'(0), thr_dat_i};
        wr_next = (idx_inc < cnt_q) ? S_FETCH : S_COMMIT;
        if (wb_cyc_o && wb_ack_i) begin
          idx_d = idx_inc;
        end
      end
      S_COMMIT: begin
        wr_req   = 1'b1;
        wr_adr   = UPDATE_ADDR;
        wr_dat   = COMMIT_WD;
        wr_next  = S_SETTLE;
        settle_d = '0;
      end
      S_SETTLE: begin
        if (settle_q == SET_LAST) begin
          state_d = S_RESTORE;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_RESTORE: begin
        wr_req  = 1'b1;
        wr_adr  = MASK_ADDR;
        wr_dat  = mask_q;
        wr_next = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Classic single write: issue on an idle cycle, hold until ack or timeout
    if (wr_req) begin
      if (!wb_cyc_o) begin
        cyc_d = 1'b1;
        adr_d = wr_adr;
        dat_d = wr_dat;
      end else if (wb_ack_i) begin
        state_d = wr_next;
        done_d  = (wr_next == S_DONE);
      end else if (timeout_c) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        cyc_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      settle_q  <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      thr_rd_o  <= 1'b0;
      thr_idx_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      settle_q  <= settle_d;
      wb_cyc_o  <= cyc_d;
      wb_stb_o  <= cyc_d;
      wb_we_o   <= cyc_d;
      wb_adr_o  <= adr_d;
      wb_dat_o  <= dat_d;
      thr_rd_o  <= rd_d;
      thr_idx_o <= tidx_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
    end
  end

endmodule
